// File: rtl/frogger_pkg.sv
// Shared constants, lane period table and scheduler state encoding.
// Collision checking is enabled with the TRAFFIC_COLLISION_EN macro.
package frogger_pkg;

    localparam int NUM_CARS  = 16;
    localparam int GRID_COLS = 20;
    localparam int NUM_LANES = 8;
    localparam int LANE_ROW0 = 3;
    localparam int XW        = 5;
    localparam int YW        = 4;
    localparam int PW        = 3;

    localparam logic [PW-1:0] BASE_PERIOD [NUM_LANES] = '{
        3'd4, 3'd3, 3'd2, 3'd5, 3'd3, 3'd4, 3'd2, 3'd6
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    function automatic logic [PW-1:0] eff_period(
        input logic [PW-1:0] base,
        input logic [1:0]    level
    );
        logic [PW-1:0] p;
        p = base >> level;
        return (p == '0) ? PW'(1) : p;
    endfunction

endpackage

// File: rtl/lane_timer.sv
// Per-lane frame counter; ticks when the level-scaled period elapses.
module lane_timer
    import frogger_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    input  logic [1:0] level,
    output logic       tick
);

    localparam logic [PW-1:0] BASE = BASE_PERIOD[LANE % NUM_LANES];

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;
    logic [PW-1:0] last;

    // >= so a counter left above a shortened period still ticks
    always_comb begin
        last  = eff_period(BASE, level) - PW'(1);
        tick  = (cnt_q >= last);
        cnt_d = cnt_q;
        if (advance) begin
            cnt_d = tick ? '0 : cnt_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_scheduler.sv
// Frame-driven car mover: one slot per cycle, then optional collision check.
// Collision check and hit pulse exist only with TRAFFIC_COLLISION_EN.
module traffic_scheduler #(
    parameter int NUM_CARS  = frogger_pkg::NUM_CARS,
    parameter int GRID_COLS = frogger_pkg::GRID_COLS,
    parameter int LANE_ROW0 = frogger_pkg::LANE_ROW0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  game_run,
    input  logic [1:0]            level,
    input  logic [4:0]            frog_col,
    input  logic [3:0]            frog_row,
    output logic [NUM_CARS*5-1:0] car_x,
    output logic [NUM_CARS*4-1:0] car_y,
    output logic                  busy,
    output logic                  hit,
    output logic                  overrun
);

    import frogger_pkg::state_t;
    import frogger_pkg::ST_IDLE;
    import frogger_pkg::ST_SCAN;
`ifdef TRAFFIC_COLLISION_EN
    import frogger_pkg::ST_CHECK;
`endif

    localparam int LANES = NUM_CARS / 2;
    localparam int IW    = $clog2(NUM_CARS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CARS - 1);
    localparam logic [4:0]    LAST_COL = 5'(GRID_COLS - 1);

    state_t         state_q;
    state_t         state_d;
    logic [IW-1:0]  idx_q;
    logic [IW-1:0]  idx_d;
    logic [LANES-1:0] tick;
    logic [LANES-1:0] tick_q;
    logic [LANES-1:0] tick_d;
    logic [4:0]     x_q [NUM_CARS];
    logic [4:0]     x_d [NUM_CARS];
    logic           overrun_q;
    logic           overrun_d;
    logic           accept;
    logic [IW-2:0]  lane;
    logic [4:0]     cur_x;
    logic [4:0]     nxt_x;

    assign accept = frame_start & game_run & (state_q == ST_IDLE);
    assign lane   = idx_q[IW-1:1];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        lane_timer #(
            .LANE (l)
        ) u_timer (
            .clk     (clk),
            .rst_n   (rst_n),
            .advance (accept),
            .level   (level),
            .tick    (tick[l])
        );
    end

    // odd lanes run right-to-left
    always_comb begin
        cur_x = x_q[idx_q];
        if (lane[0]) begin
            nxt_x = (cur_x == 5'd0) ? LAST_COL : cur_x - 5'd1;
        end else begin
            nxt_x = (cur_x == LAST_COL) ? 5'd0 : cur_x + 5'd1;
        end
    end

`ifdef TRAFFIC_COLLISION_EN
    logic hit_q;
    logic hit_d;
    logic match;

    always_comb begin
        match = 1'b0;
        for (int s = 0; s < NUM_CARS; s++) begin
            if (x_q[s] == frog_col &&
                4'(LANE_ROW0 + s / 2) == frog_row) begin
                match = 1'b1;
            end
        end
    end

    assign hit = hit_q;
`else
    logic unused_frog;
    assign unused_frog = ^{frog_col, frog_row};
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tick_d    = tick_q;
        x_d       = x_q;
        overrun_d = overrun_q | (frame_start & (state_q != ST_IDLE));
`ifdef TRAFFIC_COLLISION_EN
        hit_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    tick_d  = tick;
                end
            end
            ST_SCAN: begin
                if (tick_q[lane]) begin
                    x_d[idx_q] = nxt_x;
                end
                if (idx_q == LAST_IDX) begin
`ifdef TRAFFIC_COLLISION_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
`ifdef TRAFFIC_COLLISION_EN
            ST_CHECK: begin
                hit_d   = match;
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            tick_q    <= '0;
            overrun_q <= 1'b0;
            for (int s = 0; s < NUM_CARS; s++) begin
                x_q[s] <= (s % 2 == 1) ? 5'd10 : 5'(s / 2);
            end
`ifdef TRAFFIC_COLLISION_EN
            hit_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tick_q    <= tick_d;
            overrun_q <= overrun_d;
            x_q       <= x_d;
`ifdef TRAFFIC_COLLISION_EN
            hit_q     <= hit_d;
`endif
        end
    end

    for (genvar s = 0; s < NUM_CARS; s++) begin : g_out
        assign car_x[s*5 +: 5] = x_q[s];
        assign car_y[s*4 +: 4] = 4'(LANE_ROW0 + s / 2);
    end

    assign busy    = (state_q != ST_IDLE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_traffic_scheduler.sv
// Randomized scoreboard bench for traffic_scheduler.
// Expected frames come from a lane/slot arithmetic model.
module tb_traffic_scheduler;

    localparam int NC   = 16;
    localparam int GC   = 20;
    localparam int ROW0 = 3;
`ifdef TRAFFIC_COLLISION_EN
    localparam bit COLL = 1'b1;
    localparam int LAT  = 18;
`else
    localparam bit COLL = 1'b0;
    localparam int LAT  = 17;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic        game_run;
    logic [1:0]  level;
    logic [4:0]  frog_col;
    logic [3:0]  frog_row;
    logic [79:0] car_x;
    logic [63:0] car_y;
    logic        busy;
    logic        hit;
    logic        overrun;

    traffic_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .game_run    (game_run),
        .level       (level),
        .frog_col    (frog_col),
        .frog_row    (frog_row),
        .car_x       (car_x),
        .car_y       (car_y),
        .busy        (busy),
        .hit         (hit),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int base_p [8] = '{4, 3, 2, 5, 3, 4, 2, 6};
    int m_x   [NC];
    int m_ctr [8];

    typedef struct {
        logic [79:0] x;
        logic        hit;
        int          cyc;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    bit   mon_en      = 1'b0;
    logic prev_busy   = 1'b0;
    bit   chk_hit_low = 1'b0;
    bit   rand_frog   = 1'b0;

    task automatic check(input string name,
                         input logic [79:0] act,
                         input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h",
                     name, act, exp);
        end
    endtask

    function automatic logic [79:0] pack_x();
        logic [79:0] v;
        v = '0;
        for (int s = 0; s < NC; s++) v[s*5 +: 5] = 5'(m_x[s]);
        return v;
    endfunction

    function automatic logic [63:0] exp_y();
        logic [63:0] v;
        v = '0;
        for (int s = 0; s < NC; s++) v[s*4 +: 4] = 4'(ROW0 + s / 2);
        return v;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NC; s++) m_x[s] = (s % 2 == 1) ? 10 : s / 2;
        for (int l = 0; l < 8; l++) m_ctr[l] = 0;
    endtask

    task automatic model_frame();
        int   eff;
        bit   any;
        int   s;
        exp_t e;
        for (int l = 0; l < 8; l++) begin
            eff = base_p[l] >> level;
            if (eff < 1) eff = 1;
            if (m_ctr[l] >= eff - 1) begin
                m_ctr[l] = 0;
                for (int k = 2 * l; k < 2 * l + 2; k++) begin
                    if (l % 2 == 0) m_x[k] = (m_x[k] + 1) % GC;
                    else            m_x[k] = (m_x[k] + GC - 1) % GC;
                end
            end else begin
                m_ctr[l]++;
            end
        end
        if (rand_frog) begin
            if ($urandom_range(1) == 1) begin
                s        = $urandom_range(NC - 1);
                frog_col = 5'(m_x[s]);
                frog_row = 4'(ROW0 + s / 2);
            end else begin
                frog_col = 5'($urandom_range(31));
                frog_row = 4'($urandom_range(15));
            end
        end
        any = 1'b0;
        for (int k = 0; k < NC; k++) begin
            if (m_x[k] == int'(frog_col) && ROW0 + k / 2 == int'(frog_row))
                any = 1'b1;
        end
        e.x   = pack_x();
        e.hit = COLL & any;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic issue_frame(input bit run);
        @(negedge clk);
        game_run    = run;
        frame_start = 1'b1;
        if (run) model_frame();
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic settle();
        repeat (22) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en      = 1'b0;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        sb.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_x"}, car_x, pack_x());
        check({tag, "_y"}, car_y, exp_y());
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (chk_hit_low) begin
                check("hit_width", hit, 1'b0);
                chk_hit_low = 1'b0;
            end
            if (prev_busy && !busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_end actual=unexpected required=none");
                end else begin
                    mon_e = sb.pop_front();
                    check("frame_x", car_x, mon_e.x);
                    check("frame_y", car_y, exp_y());
                    check("frame_hit", hit, mon_e.hit);
                    check("latency", 80'(cyc - mon_e.cyc), 80'(LAT));
                    if (mon_e.hit) chk_hit_low = 1'b1;
                end
            end
        end
        prev_busy = busy;
    end

    initial begin
        bit run;
        rst_n       = 1'b1;
        frame_start = 1'b0;
        game_run    = 1'b0;
        level       = 2'd0;
        frog_col    = 5'd31;
        frog_row    = 4'd15;
        do_reset();

        check("rst_s0_x", car_x[4:0], 0);
        check("rst_s0_y", car_y[3:0], 3);
        check("rst_s1_x", car_x[9:5], 10);
        check("rst_s14_x", car_x[74:70], 7);
        check("rst_s14_y", car_y[59:56], 10);
        check("rst_s15_x", car_x[79:75], 10);
        check("rst_s15_y", car_y[63:60], 10);
        check("rst_busy", busy, 0);
        check("rst_hit", hit, 0);
        check("rst_overrun", overrun, 0);
        check_pos("rst");

        issue_frame(1'b1);
        settle();
        issue_frame(1'b1);
        settle();
        check("f2_s4_x", car_x[24:20], 3);
        check("f2_s5_x", car_x[29:25], 11);
        check("f2_s0_x", car_x[4:0], 0);
        check("f2_s1_x", car_x[9:5], 10);
        issue_frame(1'b1);
        settle();
        frog_col = 5'd11;
        frog_row = 4'd3;
        issue_frame(1'b1);
        settle();
        check("f4_s0_x", car_x[4:0], 1);
        check("f4_s1_x", car_x[9:5], 11);
        frog_col = 5'd31;
        frog_row = 4'd15;

        issue_frame(1'b0);
        settle();
        check_pos("norun");

        check("ovr_before", overrun, 0);
        issue_frame(1'b1);
        repeat (5) @(negedge clk);
        frame_start = 1'b1;
        game_run    = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        settle();
        check("ovr_after", overrun, 1);
        check_pos("ovr");

        issue_frame(1'b1);
        @(negedge clk);
        game_run = 1'b0;
        settle();
        check_pos("run_drop");

        rand_frog = 1'b1;
        repeat (60) begin
            level = 2'($urandom_range(3));
            run   = ($urandom_range(3) != 0);
            issue_frame(run);
            settle();
        end
        rand_frog = 1'b0;
        frog_col  = 5'd31;
        frog_row  = 4'd15;
        check("ovr_sticky", overrun, 1);
        check_pos("random");

        level = 2'd3;
        issue_frame(1'b1);
        settle();
        issue_frame(1'b1);
        repeat (6) @(negedge clk);
        do_reset();
        check_pos("mid_rst");
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ovr", overrun, 0);

        level = 2'd0;
        repeat (2) begin
            issue_frame(1'b1);
            settle();
        end

        repeat (5) @(negedge clk);
        check("sb_empty", 80'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
